operand_loader: RTL and testbench

- Write-side counterpart to the operand read-address controller of the MAC systolic array.
- Accepts matrices A and B (each M x M) as one valid/ready element stream, row-major, A first then B.
- Scatters elements into the banked operand memories: N1 row-banks for A, N2 column-banks for B.
- Uses the same bank/address mapping the read controller sweeps: bank-local address = slice*M + pixel.

---
 rtl/operand_loader.sv | 112 +++++++++++
 tb/tb_operand_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Write-side operand loader: scatters a row-major A-then-B element stream into
// the banked operand memories using the read controller's bank/address mapping.
module operand_loader #(
  parameter int N1  = 4,
  parameter int N2  = 4,
  parameter int M   = 8,
  parameter int D_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           op_release,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [D_W-1:0]                 in_data,
  output logic [N1-1:0]                  wr_en_A,
  output logic [$clog2((M*M)/N1)-1:0]    wr_addr_A,
  output logic [D_W-1:0]                 wr_data_A,
  output logic [N2-1:0]                  wr_en_B,
  output logic [$clog2((M*M)/N2)-1:0]    wr_addr_B,
  output logic [D_W-1:0]                 wr_data_B,
  output logic                           busy,
  output logic                           load_done
);

  localparam int RW   = (M > 1) ? $clog2(M) : 1;
  localparam int LN1  = $clog2(N1);
  localparam int LN2  = $clog2(N2);
  localparam int AW_A = $clog2((M*M)/N1);
  localparam int AW_B = $clog2((M*M)/N2);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]      state;
  logic [RW-1:0]   r;
  logic [RW-1:0]   c;
  logic            beat;
  logic            last;
  logic [N1-1:0]   bank_a;
  logic [N2-1:0]   bank_b;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign busy      = in_ready;
  assign load_done = (state == DONE);
  assign beat      = in_valid && in_ready;
  assign last      = (r == RW'(M-1)) && (c == RW'(M-1));

  // Power-of-two parameters: mod is a mask, divide is a shift.
  always_comb begin
    bank_a = N1'(1) << (r & RW'(N1-1));
    addr_a = AW_A'(((32'(r) >> LN1) * 32'(M)) + 32'(c));
    bank_b = N2'(1) << (c & RW'(N2-1));
    addr_b = AW_B'(((32'(c) >> LN2) * 32'(M)) + 32'(r));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      wr_en_A   <= '0;
      wr_addr_A <= '0;
      wr_data_A <= '0;
      wr_en_B   <= '0;
      wr_addr_B <= '0;
      wr_data_B <= '0;
    end else begin
      wr_en_A <= '0;
      wr_en_B <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_A;
            r     <= '0;
            c     <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (beat) begin
            if (state == LOAD_A) begin
              wr_en_A   <= bank_a;
              wr_addr_A <= addr_a;
              wr_data_A <= in_data;
            end else begin
              wr_en_B   <= bank_b;
              wr_addr_B <= addr_b;
              wr_data_B <= in_data;
            end
            if (last) begin
              r     <= '0;
              c     <= '0;
              state <= (state == LOAD_A) ? LOAD_B : DONE;
            end else begin
              c <= c + RW'(1);
              if (c == RW'(M-1)) r <= r + RW'(1);
            end
          end
        end
        DONE: begin
          if (op_release) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: reset, mapping, backpressure, handshake
// guards, mid-load reset and a second parameter set.
module tb_operand_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op_release;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] wr_en_A;
  logic [3:0] wr_addr_A;
  logic [7:0] wr_data_A;
  logic [3:0] wr_en_B;
  logic [3:0] wr_addr_B;
  logic [7:0] wr_data_B;
  logic       busy;
  logic       load_done;

  logic       start2;
  logic       valid2;
  logic       ready2;
  logic [7:0] data2;
  logic [1:0] en_a2;
  logic [6:0] addr_a2;
  logic [7:0] data_a2;
  logic [7:0] en_b2;
  logic [4:0] addr_b2;
  logic [7:0] data_b2;
  logic       busy2;
  logic       done2;

  int n_chk  = 0;
  int n_fail = 0;
  int na     = 0;
  int nb     = 0;
  int a0;
  int b0;
  logic [7:0] mem_a [4][16];
  logic [7:0] mem_b [4][16];

  operand_loader #(.N1(4), .N2(4), .M(8), .D_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_release(op_release),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en_A(wr_en_A), .wr_addr_A(wr_addr_A), .wr_data_A(wr_data_A),
    .wr_en_B(wr_en_B), .wr_addr_B(wr_addr_B), .wr_data_B(wr_data_B),
    .busy(busy), .load_done(load_done)
  );

  operand_loader #(.N1(2), .N2(8), .M(16), .D_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_release(1'b0),
    .in_valid(valid2), .in_ready(ready2), .in_data(data2),
    .wr_en_A(en_a2), .wr_addr_A(addr_a2), .wr_data_A(data_a2),
    .wr_en_B(en_b2), .wr_addr_B(addr_b2), .wr_data_B(data_b2),
    .busy(busy2), .load_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaves as the banked memories: captures strobed writes on the clock edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_A[b]) begin
        mem_a[b][wr_addr_A] <= wr_data_A;
        na <= na + 1;
      end
      if (wr_en_B[b]) begin
        mem_b[b][wr_addr_B] <= wr_data_B;
        nb <= nb + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) begin
        mem_a[b][a] = 8'hFF;
        mem_b[b][a] = 8'hFF;
      end
  endtask

  // Element (r,c) of A carries beat r*8+c; element (r,c) of B carries 64+r*8+c.
  task automatic check_image(input string tag);
    int errs;
    errs = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (mem_a[r % 4][(r / 4) * 8 + c] !== 8'(r * 8 + c)) errs++;
        if (mem_b[c % 4][(c / 4) * 8 + r] !== 8'(64 + r * 8 + c)) errs++;
      end
    chk(tag, errs, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en_A"}, wr_en_A, 0);
    chk({tag, "_wr_en_B"}, wr_en_B, 0);
    chk({tag, "_wr_addr_A"}, wr_addr_A, 0);
    chk({tag, "_wr_addr_B"}, wr_addr_B, 0);
    chk({tag, "_wr_data_A"}, wr_data_A, 0);
    chk({tag, "_wr_data_B"}, wr_data_B, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_done"}, load_done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op_release = 1'b0; in_valid = 1'b0; in_data = '0;
    start2 = 1'b0; valid2 = 1'b0; data2 = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Gapless load
    clear_mem(); a0 = na; b0 = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", in_ready, 1);
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(negedge clk);
      chk("one_strobe", $countones(wr_en_A) + $countones(wr_en_B), 1);
      if (i == 0) begin
        chk("beat0_en_A", wr_en_A, 4'b0001);
        chk("beat0_addr_A", wr_addr_A, 0);
        chk("beat0_data_A", wr_data_A, 8'h00);
      end
      if (i == 43) begin
        chk("beat43_en_A", wr_en_A, 4'b0010);
        chk("beat43_addr_A", wr_addr_A, 11);
        chk("beat43_data_A", wr_data_A, 43);
      end
      if (i == 86) begin
        chk("beat86_en_B", wr_en_B, 4'b0100);
        chk("beat86_addr_B", wr_addr_B, 10);
        chk("beat86_data_B", wr_data_B, 86);
        chk("beat86_en_A", wr_en_A, 0);
      end
      if (i == 126) chk("done_not_early", load_done, 0);
      if (i == 127) begin
        chk("beat127_en_B", wr_en_B, 4'b1000);
        chk("beat127_addr_B", wr_addr_B, 15);
        chk("beat127_data_B", wr_data_B, 8'h7F);
        chk("beat127_done", load_done, 1);
        chk("beat127_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("gapless_count_A", na - a0, 64);
    chk("gapless_count_B", nb - b0, 64);
    check_image("gapless_image");
    op_release = 1'b1;
    @(negedge clk);
    op_release = 1'b0;
    chk("release_done", load_done, 0);
    chk("release_busy", busy, 0);

    // Alternating valid, with a stray start while in LOAD_B
    clear_mem(); a0 = na; b0 = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 8'(k / 2);
      start    = (k == 140);
      @(negedge clk);
      if (k % 2 == 0) chk("strobe_after_beat", $countones(wr_en_A) + $countones(wr_en_B), 1);
      else            chk("no_strobe_after_gap", $countones(wr_en_A) + $countones(wr_en_B), 0);
    end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_count_A", na - a0, 64);
    chk("bp_count_B", nb - b0, 64);
    check_image("bp_image");
    chk("bp_done", load_done, 1);

    // start and release together in DONE: release wins, start is dropped
    start = 1'b1; op_release = 1'b1;
    @(negedge clk);
    start = 1'b0; op_release = 1'b0;
    chk("both_ready", in_ready, 0);
    chk("both_done", load_done, 0);
    chk("both_busy", busy, 0);
    @(negedge clk);
    chk("start_dropped", busy, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAB;
    @(negedge clk);
    chk("restart_en_A", wr_en_A, 4'b0001);
    chk("restart_addr_A", wr_addr_A, 0);
    chk("restart_data_A", wr_data_A, 8'hAB);
    chk("restart_en_B", wr_en_B, 0);

    // Feed through beat 90, then reset asynchronously mid-LOAD_B
    a0 = na; b0 = nb;
    for (int i = 1; i <= 90; i++) begin
      in_data = 8'(i);
      @(negedge clk);
    end
    chk("beat90_en_B", wr_en_B, 4'b0100);
    chk("beat90_addr_B", wr_addr_B, 3);
    chk("beat90_data_B", wr_data_B, 90);
    #2 rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    chk("midreset_edge_en_A", wr_en_A, 0);
    chk("midreset_edge_en_B", wr_en_B, 0);
    chk("midreset_strobes", (na - a0) + (nb - b0), 90);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5C;
    @(negedge clk);
    in_valid = 1'b0;
    chk("postreset_en_A", wr_en_A, 4'b0001);
    chk("postreset_addr_A", wr_addr_A, 0);
    chk("postreset_data_A", wr_data_A, 8'h5C);

    // M=16, N1=2, N2=8 instance
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      valid2 = 1'b1;
      data2  = 8'(i);
      @(negedge clk);
      if (i == 63) begin
        chk("p2_A_en", en_a2, 2'b10);
        chk("p2_A_addr", addr_a2, 31);
        chk("p2_A_data", data_a2, 63);
      end
      if (i == 410) begin
        chk("p2_B_en", en_b2, 8'b0000_0100);
        chk("p2_B_addr", addr_b2, 25);
        chk("p2_B_data", data_b2, 154);
      end
      if (i == 511) chk("p2_done", done2, 1);
    end
    valid2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
